// File: rtl/eth_tlp_rrarb_if.sv
// Handshake bundle between the two FWFT source FIFOs, the arbiter
// and the arb->encap output FIFO.
interface eth_tlp_rrarb_if;
  logic [73:0] fifo0_dout;
  logic        fifo0_empty;
  logic        fifo0_rd_en;
  logic [73:0] fifo1_dout;
  logic        fifo1_empty;
  logic        fifo1_rd_en;
  logic [75:0] din;
  logic        wr_en;
  logic        full;

  modport master (
    input  fifo0_dout,
    input  fifo0_empty,
    output fifo0_rd_en,
    input  fifo1_dout,
    input  fifo1_empty,
    output fifo1_rd_en,
    output din,
    output wr_en,
    input  full
  );

  modport slave (
    output fifo0_dout,
    output fifo0_empty,
    input  fifo0_rd_en,
    output fifo1_dout,
    output fifo1_empty,
    input  fifo1_rd_en,
    input  din,
    input  wr_en,
    output full
  );
endinterface

// File: rtl/eth_tlp_rrarb.sv
// Packet-granular round-robin merge of the CQ/CC TLP tap FIFOs into the
// encap FIFO, with runaway-packet truncation and per-source statistics.
module eth_tlp_rrarb #(
  parameter int unsigned MAX_BEATS = 64,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk156,
  input  logic                 sys_rst_n,
  eth_tlp_rrarb_if.master      bus,
  output logic [CNT_WIDTH-1:0] pkt_cnt0,
  output logic [CNT_WIDTH-1:0] pkt_cnt1,
  output logic [CNT_WIDTH-1:0] trunc_cnt,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN
  } state_e;

  localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic                 sel_q, sel_d;
  logic                 last_q, last_d;
  logic [15:0]          beat_q, beat_d;
  logic [CNT_WIDTH-1:0] pc0_q, pc0_d;
  logic [CNT_WIDTH-1:0] pc1_q, pc1_d;
  logic [CNT_WIDTH-1:0] tc_q, tc_d;

  logic [73:0] word;
  logic        src_empty;
  logic        force_end;
  logic        pop;
  logic        wr;

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      beat_q  <= '0;
      pc0_q   <= '0;
      pc1_q   <= '0;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    beat_d  = beat_q;
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    tc_d    = tc_q;
    pop     = 1'b0;
    wr      = 1'b0;

    word      = sel_q ? bus.fifo1_dout : bus.fifo0_dout;
    src_empty = sel_q ? bus.fifo1_empty : bus.fifo0_empty;
    force_end = (beat_q == LAST_BEAT) && !word[73];

    unique case (state_q)
      IDLE: begin
        if (!bus.fifo0_empty || !bus.fifo1_empty) begin
          // Tie goes to whoever did not finish the previous packet.
          if (!bus.fifo0_empty && !bus.fifo1_empty)
            sel_d = ~last_q;
          else
            sel_d = bus.fifo0_empty;
          state_d = XFER;
        end
      end
      XFER: begin
        pop = !src_empty && !bus.full;
        wr  = pop;
        if (pop) begin
          beat_d = beat_q + 16'd1;
          if (word[73] || force_end) begin
            beat_d = '0;
            last_d = sel_q;
            if (sel_q)
              pc1_d = pc1_q + ONE;
            else
              pc0_d = pc0_q + ONE;
            if (word[73]) begin
              state_d = IDLE;
            end else begin
              tc_d    = tc_q + ONE;
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        pop = !src_empty;
        if (pop && word[73])
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.fifo0_rd_en = pop && !sel_q;
  assign bus.fifo1_rd_en = pop && sel_q;
  assign bus.wr_en       = wr;
  assign bus.din = {
    sel_q ? 2'b10 : 2'b01,
    word[73] | force_end,
    word[72] | force_end,
    word[71:0]
  };

  assign pkt_cnt0  = pc0_q;
  assign pkt_cnt1  = pc1_q;
  assign trunc_cnt = tc_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_eth_tlp_rrarb.sv
// Directed bench for eth_tlp_rrarb: queue-modelled source FIFOs and
// an output scoreboard filled as packets are loaded.
module tb_eth_tlp_rrarb;
  localparam int MAXB = 4;
  localparam int CW   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_tlp_rrarb_if bus();
  logic [CW-1:0] pc0, pc1, tc;
  logic          busy;

  eth_tlp_rrarb #(.MAX_BEATS(MAXB), .CNT_WIDTH(CW)) dut (
    .clk156   (clk),
    .sys_rst_n(rst_n),
    .bus      (bus),
    .pkt_cnt0 (pc0),
    .pkt_cnt1 (pc1),
    .trunc_cnt(tc),
    .busy     (busy)
  );

  logic [73:0] q0[$];
  logic [73:0] q1[$];
  logic [75:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic        p0, p1, pw, pf;
  logic [75:0] pd;

  task automatic check(string tag, logic [75:0] obs, logic [75:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    bus.fifo0_empty = (q0.size() == 0);
    bus.fifo0_dout  = (q0.size() != 0) ? q0[0] : 74'd0;
    bus.fifo1_empty = (q1.size() == 0);
    bus.fifo1_dout  = (q1.size() != 0) ? q1[0] : 74'd0;
  endtask

  function automatic logic [73:0] mkw(bit last, int tag);
    return {last, 1'b0, 8'hff, 64'(tag) ^ 64'h5a5a_0000_0000_0000};
  endfunction

  // Beats past MAXB are discarded; beat MAXB of a longer packet carries forced flags.
  task automatic push_pkt(int src, int n, int base);
    logic [73:0] wd;
    logic [75:0] e;
    for (int i = 0; i < n; i++) begin
      wd = mkw(i == n - 1, base + i);
      if (src == 0) q0.push_back(wd);
      else q1.push_back(wd);
      if (i < MAXB) begin
        e = {(src == 0) ? 2'b01 : 2'b10, wd};
        if (i == MAXB - 1 && n > MAXB) e[73:72] = 2'b11;
        exp_q.push_back(e);
      end
    end
    refresh();
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic wait_drain(int budget);
    int k = 0;
    while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0)
           && k < budget) begin
      step(1);
      k++;
    end
    check("drained", {exp_q.size() == 0, q0.size() == 0, q1.size() == 0},
          3'b111);
    step(2);
  endtask

  always @(posedge clk) begin
    p0 <= bus.fifo0_rd_en;
    p1 <= bus.fifo1_rd_en;
    pw <= bus.wr_en;
    pf <= bus.full;
    pd <= bus.din;
  end

  always @(negedge clk) begin
    check("rd_excl", p0 & p1, 0);
    check("wr_full", pw & pf, 0);
    if (p0) begin
      check("pop0_nonempty", q0.size() != 0, 1);
      if (q0.size() != 0) void'(q0.pop_front());
    end
    if (p1) begin
      check("pop1_nonempty", q1.size() != 0, 1);
      if (q1.size() != 0) void'(q1.pop_front());
    end
    if (pw) begin
      check("wr_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("din", pd, exp_q.pop_front());
    end
    refresh();
  end

  initial begin
    bus.full = 1'b0;
    refresh();

    // Alternating arbitration from reset, src0 first.
    for (int i = 0; i < 4; i++) begin
      push_pkt(0, 2, 16 * i);
      push_pkt(1, 2, 16 * i + 8);
    end
    step(2);
    check("rst_busy", busy, 0);
    check("rst_rd0", bus.fifo0_rd_en, 0);
    check("rst_rd1", bus.fifo1_rd_en, 0);
    check("rst_wr", bus.wr_en, 0);
    check("rst_cnts", {pc0, pc1, tc}, 0);
    rst_n = 1'b1;
    wait_drain(100);
    check("rr_pc0", pc0, 4);
    check("rr_pc1", pc1, 4);

    // Single 3-beat packet: one bubble then three back-to-back writes.
    push_pkt(0, 3, 100);
    check("t1_bubble_wr", bus.wr_en, 0);
    check("t1_bubble_rd", bus.fifo0_rd_en, 0);
    step(1);
    check("t1_b1", {bus.wr_en, bus.fifo0_rd_en, busy}, 3'b111);
    step(1);
    check("t1_b2", bus.wr_en, 1);
    step(1);
    check("t1_b3", bus.wr_en, 1);
    step(1);
    check("t1_end", {bus.wr_en, busy}, 2'b00);
    check("t1_pc0", pc0, 5);
    wait_drain(50);

    // Output FIFO full for 10 cycles while beat 2 is presented.
    push_pkt(0, MAXB, 200);
    step(2);
    bus.full = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("stall", {bus.wr_en, bus.fifo0_rd_en, busy}, 3'b001);
      step(1);
    end
    bus.full = 1'b0;
    #1;
    check("resume_wr", bus.wr_en, 1);
    check("resume_din", bus.din, {2'b01, mkw(0, 201)});
    wait_drain(50);
    check("exact_max_pc0", pc0, 6);
    check("exact_max_tc", tc, 0);

    // Runaway src1 packet truncated at MAXB, then a 1-beat packet.
    push_pkt(1, 7, 300);
    push_pkt(1, 1, 400);
    wait_drain(100);
    check("trunc_tc", tc, 1);
    check("trunc_pc1", pc1, 6);

    // Reset during beat 2: remainder becomes a fresh packet.
    push_pkt(0, 4, 500);
    step(2);
    check("t6_pre", bus.fifo0_rd_en, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rd", {bus.fifo0_rd_en, bus.fifo1_rd_en}, 0);
    check("t6_wr", bus.wr_en, 0);
    check("t6_busy", busy, 0);
    check("t6_cnts", {pc0, pc1, tc}, 0);
    step(2);
    rst_n = 1'b1;
    wait_drain(50);
    check("t6_pc0", pc0, 1);
    check("t6_tc", tc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
